// File: rtl/hilo_unit_if.sv
// Bus bundle between the issue stage and the HI/LO result stage: mul/div launch,
// move-to/move-from accesses and the status flags returned by the stage.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 op_div;
  logic [WIDTH-1:0]     src_b;
  logic [2*WIDTH-1:0]   md_result;
  logic                 wr_hi;
  logic                 wr_lo;
  logic [WIDTH-1:0]     wr_data;
  logic                 rd_en;
  logic                 rd_sel;
  logic [WIDTH-1:0]     rd_data;
  logic                 busy;
  logic                 stall;
  logic                 done;
  logic                 div_zero;

  modport master (
    output start, op_div, src_b, md_result, wr_hi, wr_lo, wr_data, rd_en, rd_sel,
    input  rd_data, busy, stall, done, div_zero
  );

  modport slave (
    input  start, op_div, src_b, md_result, wr_hi, wr_lo, wr_data, rd_en, rd_sel,
    output rd_data, busy, stall, done, div_zero
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO result stage: captures the mul/div result at launch, holds it for the
// fixed operation latency, then commits it to the architectural HI/LO registers.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        reset,
  hilo_unit_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               div_by_zero;
  assign div_by_zero = bus.op_div && (bus.src_b == '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Move-to writes land now; an op launched alongside overwrites them on commit.
        if (bus.wr_hi) hi_d = bus.wr_data;
        if (bus.wr_lo) lo_d = bus.wr_data;
        if (bus.start) begin
          if (div_by_zero) begin
            div_zero_d = 1'b1;
          end else begin
            if (bus.op_div) begin
              // Divider packs {quotient, remainder}; HI takes the remainder.
              pend_hi_d = bus.md_result[WIDTH-1:0];
              pend_lo_d = bus.md_result[2*WIDTH-1:WIDTH];
              cnt_d     = CNT_W'(DIV_LAT - 1);
            end else begin
              pend_hi_d = bus.md_result[2*WIDTH-1:WIDTH];
              pend_lo_d = bus.md_result[WIDTH-1:0];
              cnt_d     = CNT_W'(MUL_LAT - 1);
            end
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q == BUSY);
  assign bus.stall    = bus.busy && (bus.start || bus.wr_hi || bus.wr_lo || bus.rd_en);
  assign bus.rd_data  = bus.rd_sel ? hi_q : lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Randomised self-checking bench for hilo_unit; a transaction-level model tracks
// the architectural HI/LO values and the expected latency of every launched op.
module tb_hilo_unit;
  localparam int W  = 32;
  localparam int ML = 4;
  localparam int DL = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] hi_m, lo_m;

  task automatic clear_inputs();
    bus.start = 0; bus.op_div = 0; bus.src_b = '0; bus.md_result = '0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_sel = 0;
  endtask

  task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
    bus.rd_sel = 1'b1; #1 h = bus.rd_data;
    bus.rd_sel = 1'b0; #1 l = bus.rd_data;
  endtask

  // Launches one op at the current (post-negedge) time and follows it to the done cycle.
  task automatic run_op(input logic div, input logic [W-1:0] b, input logic [2*W-1:0] md,
                        input logic wh, input logic wl, input logic [W-1:0] wd, input string name);
    int lat;
    int nbusy;
    logic [W-1:0] eh, el, h, l;
    lat = div ? DL : ML;
    eh  = div ? md[W-1:0] : md[2*W-1:W];
    el  = div ? md[2*W-1:W] : md[W-1:0];
    bus.start = 1; bus.op_div = div; bus.src_b = b; bus.md_result = md;
    bus.wr_hi = wh; bus.wr_lo = wl; bus.wr_data = wd;
    @(negedge clk);
    clear_inputs();
    bus.md_result = {$urandom, $urandom};
    bus.src_b     = $urandom;
    if (wh) hi_m = wd;
    if (wl) lo_m = wd;
    #1 read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL %s_pre_hi: got %0h want %0h", name, h, hi_m); end
    vectors++; if (l !== lo_m) begin errors++; $display("FAIL %s_pre_lo: got %0h want %0h", name, l, lo_m); end
    nbusy = 0;
    while (bus.busy && nbusy < 100) begin
      nbusy++;
      vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL %s_done_early: got %0b want 0", name, bus.done); end
      @(negedge clk); #1;
    end
    vectors++; if (nbusy !== lat) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, nbusy, lat); end
    vectors++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s_done: got %0b want 1", name, bus.done); end
    hi_m = eh;
    lo_m = el;
    read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL %s_hi: got %0h want %0h", name, h, hi_m); end
    vectors++; if (l !== lo_m) begin errors++; $display("FAIL %s_lo: got %0h want %0h", name, l, lo_m); end
  endtask

  task automatic test_reset();
    logic [W-1:0] h, l;
    @(negedge clk);
    clear_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    hi_m = '0; lo_m = '0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    vectors++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %0b want 0", bus.div_zero); end
    read_hilo(h, l);
    vectors++; if (h !== '0) begin errors++; $display("FAIL reset_hi: got %0h want 0", h); end
    vectors++; if (l !== '0) begin errors++; $display("FAIL reset_lo: got %0h want 0", l); end
  endtask

  task automatic test_mul();
    @(negedge clk);
    run_op(1'b0, $urandom, 64'h00000001_00000000, 1'b0, 1'b0, '0, "mul");
    @(negedge clk); #1;
    vectors++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %0b want 0", bus.done); end
  endtask

  task automatic test_div();
    @(negedge clk);
    run_op(1'b1, 32'd7, {32'd14, 32'd2}, 1'b0, 1'b0, '0, "div");
  endtask

  task automatic test_div_zero();
    logic [W-1:0] h, l;
    @(negedge clk);
    clear_inputs();
    bus.wr_hi = 1; bus.wr_data = 32'd5;
    @(negedge clk);
    hi_m = 32'd5;
    clear_inputs();
    bus.start = 1; bus.op_div = 1; bus.src_b = '0; bus.md_result = {$urandom, $urandom};
    @(negedge clk);
    clear_inputs();
    #1;
    vectors++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse: got %0b want 1", bus.div_zero); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %0b want 0", bus.busy); end
    read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL dz_hi: got %0h want %0h", h, hi_m); end
    vectors++; if (l !== lo_m) begin errors++; $display("FAIL dz_lo: got %0h want %0h", l, lo_m); end
    @(negedge clk); #1;
    vectors++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_one_cycle: got %0b want 0", bus.div_zero); end
  endtask

  task automatic test_stall();
    logic [2*W-1:0] md1, md2;
    logic [W-1:0] h, l;
    int n;
    md1 = {$urandom, $urandom};
    md2 = {$urandom, $urandom};
    @(negedge clk);
    clear_inputs();
    bus.start = 1; bus.md_result = md1;
    @(negedge clk);
    bus.md_result = md2; bus.wr_hi = 1; bus.wr_data = 32'd9; bus.rd_en = 1;
    #1;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      vectors++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_high: got %0b want 1", bus.stall); end
      bus.rd_sel = 1; #1;
      vectors++; if (bus.rd_data !== hi_m) begin errors++; $display("FAIL stall_old_hi: got %0h want %0h", bus.rd_data, hi_m); end
      @(negedge clk); #1;
    end
    vectors++; if (n !== ML) begin errors++; $display("FAIL stall_busy_len: got %0d want %0d", n, ML); end
    vectors++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_drop: got %0b want 0", bus.stall); end
    hi_m = md1[2*W-1:W]; lo_m = md1[W-1:0];
    read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL stall_commit_hi: got %0h want %0h", h, hi_m); end
    vectors++; if (l !== lo_m) begin errors++; $display("FAIL stall_commit_lo: got %0h want %0h", l, lo_m); end
    // The held request is now accepted: write lands, then the second commit overwrites it.
    @(negedge clk);
    clear_inputs();
    hi_m = 32'd9;
    #1;
    vectors++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL held_launch: got %0b want 1", bus.busy); end
    read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL held_write_hi: got %0h want %0h", h, hi_m); end
    n = 0;
    while (bus.busy && n < 100) begin n++; @(negedge clk); #1; end
    hi_m = md2[2*W-1:W]; lo_m = md2[W-1:0];
    read_hilo(h, l);
    vectors++; if (h !== hi_m) begin errors++; $display("FAIL held_commit_hi: got %0h want %0h", h, hi_m); end
    vectors++; if (l !== lo_m) begin errors++; $display("FAIL held_commit_lo: got %0h want %0h", l, lo_m); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_op(1'b0, $urandom, {$urandom, $urandom}, 1'b0, 1'b0, '0, "b2b_mul");
    run_op(1'b1, 32'd3, {$urandom, $urandom}, 1'b0, 1'b0, '0, "b2b_div");
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] h, l;
    int done_seen;
    @(negedge clk);
    clear_inputs();
    bus.start = 1; bus.op_div = 1; bus.src_b = 32'd3; bus.md_result = {$urandom, $urandom};
    @(negedge clk);
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    hi_m = '0; lo_m = '0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %0b want 0", bus.busy); end
    read_hilo(h, l);
    vectors++; if (h !== '0) begin errors++; $display("FAIL rst_mid_hi: got %0h want 0", h); end
    vectors++; if (l !== '0) begin errors++; $display("FAIL rst_mid_lo: got %0h want 0", l); end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_seen++;
      @(negedge clk); #1;
    end
    vectors++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", done_seen); end
  endtask

  task automatic test_random();
    logic div, wh, wl;
    logic [W-1:0] b, wd, h, l;
    logic [2*W-1:0] md;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      div = 1'($urandom_range(0, 1));
      b   = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
      md  = {$urandom, $urandom};
      wh  = 1'($urandom_range(0, 1));
      wl  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      if (div && b == '0) begin
        clear_inputs();
        bus.start = 1; bus.op_div = 1; bus.md_result = md;
        bus.wr_hi = wh; bus.wr_lo = wl; bus.wr_data = wd;
        @(negedge clk);
        clear_inputs();
        if (wh) hi_m = wd;
        if (wl) lo_m = wd;
        #1;
        vectors++; if (bus.div_zero !== 1'b1 || bus.busy !== 1'b0) begin
          errors++; $display("FAIL rnd_dz: got dz=%0b busy=%0b want dz=1 busy=0", bus.div_zero, bus.busy);
        end
        read_hilo(h, l);
        vectors++; if (h !== hi_m || l !== lo_m) begin
          errors++; $display("FAIL rnd_dz_regs: got %0h/%0h want %0h/%0h", h, l, hi_m, lo_m);
        end
      end else begin
        run_op(div, b, md, wh, wl, wd, "rnd_op");
      end
      if ($urandom_range(0, 1) == 1) begin
        clear_inputs();
        wh = 1'($urandom_range(0, 1)); wl = 1'($urandom_range(0, 1)); wd = $urandom;
        bus.wr_hi = wh; bus.wr_lo = wl; bus.wr_data = wd;
        @(negedge clk);
        clear_inputs();
        if (wh) hi_m = wd;
        if (wl) lo_m = wd;
        #1 read_hilo(h, l);
        vectors++; if (h !== hi_m || l !== lo_m) begin
          errors++; $display("FAIL rnd_move_to: got %0h/%0h want %0h/%0h", h, l, hi_m, lo_m);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    hi_m = '0;
    lo_m = '0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
